// File: rtl/regfile_pkg.sv
// Shared register-file constants and types.
// Imported by the operand-fetch stage and the register file.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 3;
    localparam int NREG   = 2 ** ADDR_W;
    localparam int OP_W   = 8;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [OP_W-1:0]   opcode_t;
    typedef logic [NREG-1:0]   pend_t;

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } ostate_e;

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Decode, regfile, writeback and execute signals of the operand-fetch stage.
// The slave modport is the fetch stage; master is its surroundings.
interface regfile_operand_fetch_if;
    import regfile_pkg::*;

    logic      in_valid;
    logic      in_ready;
    reg_addr_t in_src0;
    reg_addr_t in_src1;
    reg_addr_t in_dst;
    logic      in_dst_en;
    opcode_t   in_opcode;

    reg_addr_t rf_r0addr;
    reg_addr_t rf_r1addr;
    data_t     rf_r0data;
    data_t     rf_r1data;

    logic      wb_wena;
    reg_addr_t wb_waddr;
    data_t     wb_wdata;

    logic      out_valid;
    logic      out_ready;
    data_t     out_op0;
    data_t     out_op1;
    reg_addr_t out_dst;
    logic      out_dst_en;
    opcode_t   out_opcode;

    modport slave (
        input  in_valid, in_src0, in_src1, in_dst, in_dst_en, in_opcode,
        output in_ready,
        output rf_r0addr, rf_r1addr,
        input  rf_r0data, rf_r1data,
        input  wb_wena, wb_waddr, wb_wdata,
        output out_valid, out_op0, out_op1, out_dst, out_dst_en, out_opcode,
        input  out_ready
    );

    modport master (
        output in_valid, in_src0, in_src1, in_dst, in_dst_en, in_opcode,
        input  in_ready,
        input  rf_r0addr, rf_r1addr,
        output rf_r0data, rf_r1data,
        output wb_wena, wb_waddr, wb_wdata,
        input  out_valid, out_op0, out_op1, out_dst, out_dst_en, out_opcode,
        output out_ready
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared by writeback.
// Lookups already see this cycle's writeback as cleared.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      i_wb_wena,
    input  reg_addr_t i_wb_waddr,
    input  logic      i_set_en,
    input  reg_addr_t i_set_addr,
    input  reg_addr_t i_q0_addr,
    input  reg_addr_t i_q1_addr,
    input  reg_addr_t i_q2_addr,
    output logic      o_q0_pend,
    output logic      o_q1_pend,
    output logic      o_q2_pend
);

    pend_t r_pend;
    pend_t w_clr;
    pend_t w_set;
    pend_t w_eff;

    assign w_clr = i_wb_wena ? (pend_t'(1) << i_wb_waddr) : '0;
    assign w_set = i_set_en  ? (pend_t'(1) << i_set_addr) : '0;
    assign w_eff = r_pend & ~w_clr;

    assign o_q0_pend = w_eff[i_q0_addr];
    assign o_q1_pend = w_eff[i_q1_addr];
    assign o_q2_pend = w_eff[i_q2_addr];

    // OR-ing the set after the clear lets a same-cycle reissue win
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_eff | w_set;
        end
    end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch between decode and execute: hazard stall, writeback bypass,
// single-entry output register and a saturating stall counter.
module regfile_operand_fetch
    import regfile_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    regfile_operand_fetch_if.slave bus,
    output logic [15:0]            stall_cnt
);

    logic      w_e0;
    logic      w_e1;
    logic      w_e2;
    logic      w_hazard;
    logic      w_accept;
    logic      w_clr0;
    logic      w_clr1;
    logic      w_set_en;

    ostate_e   r_state;
    data_t     r_op0;
    data_t     r_op1;
    reg_addr_t r_dst;
    logic      r_dst_en;
    opcode_t   r_opcode;
    logic [15:0] r_stall;

    assign w_set_en = w_accept & bus.in_dst_en;

    regfile_scoreboard u_sb (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wb_wena  (bus.wb_wena),
        .i_wb_waddr (bus.wb_waddr),
        .i_set_en   (w_set_en),
        .i_set_addr (bus.in_dst),
        .i_q0_addr  (bus.in_src0),
        .i_q1_addr  (bus.in_src1),
        .i_q2_addr  (bus.in_dst),
        .o_q0_pend  (w_e0),
        .o_q1_pend  (w_e1),
        .o_q2_pend  (w_e2)
    );

    assign bus.rf_r0addr = bus.in_src0;
    assign bus.rf_r1addr = bus.in_src1;

    assign w_hazard = w_e0 | w_e1 | (bus.in_dst_en & w_e2);
    assign bus.in_ready = !w_hazard &&
                          (r_state == S_EMPTY || bus.out_ready);
    assign w_accept = bus.in_valid && bus.in_ready;

    // The regfile write lands on the same edge, so forward it directly
    assign w_clr0 = bus.wb_wena && (bus.wb_waddr == bus.in_src0);
    assign w_clr1 = bus.wb_wena && (bus.wb_waddr == bus.in_src1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_EMPTY;
            r_op0    <= '0;
            r_op1    <= '0;
            r_dst    <= '0;
            r_dst_en <= 1'b0;
            r_opcode <= '0;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (!w_accept && bus.out_ready) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
            if (w_accept) begin
                r_op0    <= w_clr0 ? bus.wb_wdata : bus.rf_r0data;
                r_op1    <= w_clr1 ? bus.wb_wdata : bus.rf_r1data;
                r_dst    <= bus.in_dst;
                r_dst_en <= bus.in_dst_en;
                r_opcode <= bus.in_opcode;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (bus.in_valid && w_hazard && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign bus.out_valid  = (r_state == S_FULL);
    assign bus.out_op0    = r_op0;
    assign bus.out_op1    = r_op1;
    assign bus.out_dst    = r_dst;
    assign bus.out_dst_en = r_dst_en;
    assign bus.out_opcode = r_opcode;
    assign stall_cnt      = r_stall;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: directed instructions, expected operands
// queued on issue and checked by an output monitor.
module tb_regfile_operand_fetch;
    import regfile_pkg::*;

    typedef struct packed {
        logic [63:0] op0;
        logic [63:0] op1;
        logic [2:0]  dst;
        logic        de;
        logic [7:0]  opc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] stall_cnt;
    logic [63:0] rf [8];
    exp_t        q [$];
    int          total = 0;
    int          bad = 0;

    regfile_operand_fetch_if ifc ();

    regfile_operand_fetch dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (ifc.slave),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifc.wb_wena) rf[ifc.wb_waddr] <= ifc.wb_wdata;
    end
    assign ifc.rf_r0data = rf[ifc.rf_r0addr];
    assign ifc.rf_r1data = rf[ifc.rf_r1addr];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && ifc.out_valid && ifc.out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL mon_unexpected: got opc %0h want none",
                         ifc.out_opcode);
            end else begin
                exp_t e;
                exp_t a;
                e = q.pop_front();
                a = '{ifc.out_op0, ifc.out_op1, ifc.out_dst,
                      ifc.out_dst_en, ifc.out_opcode};
                if (a !== e) begin
                    bad++;
                    $display("FAIL mon_out: got %0h/%0h d%0d e%0b o%0h want %0h/%0h d%0d e%0b o%0h",
                             a.op0, a.op1, a.dst, a.de, a.opc,
                             e.op0, e.op1, e.dst, e.de, e.opc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [63:0] d);
        ifc.wb_wena  = 1'b1;
        ifc.wb_waddr = a;
        ifc.wb_wdata = d;
        tick();
        ifc.wb_wena  = 1'b0;
    endtask

    task automatic drive(input logic [2:0] s0, input logic [2:0] s1,
                         input logic [2:0] d, input logic de,
                         input logic [7:0] opc);
        ifc.in_src0   = s0;
        ifc.in_src1   = s1;
        ifc.in_dst    = d;
        ifc.in_dst_en = de;
        ifc.in_opcode = opc;
        ifc.in_valid  = 1'b1;
    endtask

    task automatic send(input logic [2:0] s0, input logic [2:0] s1,
                        input logic [2:0] d, input logic de,
                        input logic [7:0] opc,
                        input logic [63:0] e0, input logic [63:0] e1);
        bit ok;
        ok = 1'b0;
        drive(s0, s1, d, de, opc);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_timeout: got in_ready 0 want 1 opc %0h", opc);
        end else begin
            q.push_back('{e0, e1, d, de, opc});
        end
        tick();
        ifc.in_valid = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_src0   = '0;
        ifc.in_src1   = '0;
        ifc.in_dst    = '0;
        ifc.in_dst_en = 1'b0;
        ifc.in_opcode = '0;
        ifc.wb_wena   = 1'b0;
        ifc.wb_waddr  = '0;
        ifc.wb_wdata  = '0;
        ifc.out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_op0", ifc.out_op0, 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_pend", 64'(dut.u_sb.r_pend), 64'd0);
        reset_n = 1'b1;
        tick();

        // load regfile through writebacks to non-pending registers
        wb_write(3'd0, 64'h00);
        wb_write(3'd1, 64'h11);
        wb_write(3'd2, 64'h22);
        wb_write(3'd3, 64'h33);
        wb_write(3'd4, 64'h44);
        wb_write(3'd5, 64'h55);
        wb_write(3'd6, 64'h66);
        wb_write(3'd7, 64'h77);
        chk("wb_nonpend", 64'(dut.u_sb.r_pend), 64'd0);

        // basic issue
        send(3'd1, 3'd2, 3'd3, 1'b1, 8'hA1, 64'h11, 64'h22);
        chk("t1_latency", 64'(ifc.out_valid), 64'd1);
        chk("t1_pend", 64'(dut.u_sb.r_pend), 64'h08);

        // RAW stall then bypass
        drive(3'd3, 3'd1, 3'd4, 1'b1, 8'hA2);
        repeat (3) tick();
        chk("t2_ready_lo", 64'(ifc.in_ready), 64'd0);
        chk("t2_stall", 64'(stall_cnt), 64'd3);
        ifc.wb_wena  = 1'b1;
        ifc.wb_waddr = 3'd3;
        ifc.wb_wdata = 64'hAB;
        #1;
        chk("t2_ready_hi", 64'(ifc.in_ready), 64'd1);
        q.push_back('{64'hAB, 64'h11, 3'd4, 1'b1, 8'hA2});
        tick();
        ifc.in_valid = 1'b0;
        ifc.wb_wena  = 1'b0;
        chk("t2_pend", 64'(dut.u_sb.r_pend), 64'h10);
        chk("t2_stall_hold", 64'(stall_cnt), 64'd3);

        // WAW stall, set wins
        send(3'd0, 3'd1, 3'd5, 1'b1, 8'hA3, 64'h00, 64'h11);
        chk("t3_pend_a", 64'(dut.u_sb.r_pend), 64'h30);
        drive(3'd2, 3'd6, 3'd5, 1'b1, 8'hA4);
        repeat (2) tick();
        chk("t3_ready_lo", 64'(ifc.in_ready), 64'd0);
        ifc.wb_wena  = 1'b1;
        ifc.wb_waddr = 3'd5;
        ifc.wb_wdata = 64'h5A;
        #1;
        chk("t3_ready_hi", 64'(ifc.in_ready), 64'd1);
        q.push_back('{64'h22, 64'h66, 3'd5, 1'b1, 8'hA4});
        tick();
        ifc.in_valid = 1'b0;
        ifc.wb_wena  = 1'b0;
        chk("t3_pend_b", 64'(dut.u_sb.r_pend), 64'h30);
        chk("t3_stall", 64'(stall_cnt), 64'd5);
        wb_write(3'd4, 64'h4B);
        wb_write(3'd5, 64'h5B);
        wb_write(3'd7, 64'h7B);
        chk("t3_pend_clr", 64'(dut.u_sb.r_pend), 64'h00);

        // backpressure then back-to-back transfer
        ifc.out_ready = 1'b0;
        send(3'd1, 3'd2, 3'd0, 1'b0, 8'hB1, 64'h11, 64'h22);
        drive(3'd7, 3'd3, 3'd6, 1'b1, 8'hB2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_ready_lo", 64'(ifc.in_ready), 64'd0);
            chk("t4_hold_op0", ifc.out_op0, 64'h11);
            chk("t4_hold_opc", 64'(ifc.out_opcode), 64'hB1);
        end
        chk("t4_no_stall", 64'(stall_cnt), 64'd5);
        ifc.out_ready = 1'b1;
        #1;
        chk("t4_ready_hi", 64'(ifc.in_ready), 64'd1);
        q.push_back('{64'h7B, 64'hAB, 3'd6, 1'b1, 8'hB2});
        tick();
        ifc.in_valid = 1'b0;
        chk("t4_b2b_valid", 64'(ifc.out_valid), 64'd1);
        chk("t4_b2b_opc", 64'(ifc.out_opcode), 64'hB2);
        tick();
        wb_write(3'd6, 64'h6B);

        // async reset mid-stream
        send(3'd0, 3'd0, 3'd3, 1'b1, 8'hC1, 64'h00, 64'h00);
        send(3'd1, 3'd2, 3'd5, 1'b1, 8'hC2, 64'h11, 64'h22);
        ifc.out_ready = 1'b0;
        chk("t5_pre_pend", 64'(dut.u_sb.r_pend), 64'h28);
        chk("t5_pre_valid", 64'(ifc.out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        chk("t5_valid", 64'(ifc.out_valid), 64'd0);
        chk("t5_pend", 64'(dut.u_sb.r_pend), 64'd0);
        chk("t5_op1", ifc.out_op1, 64'd0);
        chk("t5_stall", 64'(stall_cnt), 64'd0);
        tick();
        reset_n = 1'b1;
        ifc.out_ready = 1'b1;
        tick();

        // stall counter saturation
        send(3'd0, 3'd0, 3'd1, 1'b1, 8'hD1, 64'h00, 64'h00);
        drive(3'd1, 3'd0, 3'd2, 1'b0, 8'hD2);
        repeat (70000) @(posedge clk);
        #1;
        chk("t6_sat", 64'(stall_cnt), 64'hFFFF);
        repeat (5) tick();
        chk("t6_sat_hold", 64'(stall_cnt), 64'hFFFF);
        chk("t6_ready_lo", 64'(ifc.in_ready), 64'd0);
        ifc.wb_wena  = 1'b1;
        ifc.wb_waddr = 3'd1;
        ifc.wb_wdata = 64'h1B;
        q.push_back('{64'h1B, 64'h00, 3'd2, 1'b0, 8'hD2});
        tick();
        ifc.in_valid = 1'b0;
        ifc.wb_wena  = 1'b0;
        repeat (3) tick();
        chk("t6_sat_end", 64'(stall_cnt), 64'hFFFF);
        chk("q_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
